ethernetsystem_cpu_oci_dct_capture: RTL and testbench

Parametrised debug-trace capture stage for the CPU OCI path. It packs narrow trace entries into frames and holds completed frames in an internal FIFO with a valid/ready output. An end-of-test handshake flushes any partial frame, drains the FIFO, then asserts test_has_ended. It generalises the fixed 30-bit/4-bit dct_buffer/dct_count interface to configurable entry width, frame size and buffer depth.

---
 rtl/ethernetsystem_cpu_oci_pkg.sv | 22 ++
 rtl/ethernetsystem_cpu_oci_dct_capture_if.sv | 36 +++
 rtl/ethernetsystem_cpu_oci_dct_fifo.sv | 48 ++++
 rtl/ethernetsystem_cpu_oci_dct_capture.sv | 122 ++++++++++++
 tb/tb_ethernetsystem_cpu_oci_dct_capture.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ethernetsystem_cpu_oci_pkg.sv
// Shared types and default sizing for the CPU OCI debug-trace capture path.
package ethernetsystem_cpu_oci_pkg;

    localparam int DEF_ENTRY_W = 2;
    localparam int DEF_ENTRIES = 15;
    localparam int DEF_COUNT_W = 4;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_FRAME_W = DEF_ENTRY_W * DEF_ENTRIES;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_ENDED
    } state_t;

    typedef struct packed {
        logic [DEF_FRAME_W-1:0] data;
        logic [DEF_COUNT_W-1:0] count;
    } frame_t;

endpackage

// File: rtl/ethernetsystem_cpu_oci_dct_capture_if.sv
// Trace-entry input, frame output and end-of-test handshake of the capture stage.
interface ethernetsystem_cpu_oci_dct_capture_if
    import ethernetsystem_cpu_oci_pkg::*;
#(
    parameter int ENTRY_W = DEF_ENTRY_W,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int LEVEL_W = $clog2(DEF_DEPTH) + 1
);
    logic               in_valid;
    logic [ENTRY_W-1:0] in_entry;
    logic               in_ready;
    logic               test_ending;
    logic [FRAME_W-1:0] dct_buffer;
    logic [COUNT_W-1:0] dct_count;
    logic               frame_valid;
    logic               frame_ready;
    logic [FRAME_W-1:0] frame_data;
    logic [COUNT_W-1:0] frame_count;
    logic [LEVEL_W-1:0] fifo_level;
    logic               test_has_ended;

    // master = the capture stage, slave = trace source / frame consumer
    modport master (
        input  in_valid, in_entry, test_ending, frame_ready,
        output in_ready, dct_buffer, dct_count, frame_valid, frame_data,
               frame_count, fifo_level, test_has_ended
    );

    modport slave (
        output in_valid, in_entry, test_ending, frame_ready,
        input  in_ready, dct_buffer, dct_count, frame_valid, frame_data,
               frame_count, fifo_level, test_has_ended
    );

endinterface

// File: rtl/ethernetsystem_cpu_oci_dct_fifo.sv
// Generic synchronous show-ahead FIFO; a push into a full FIFO is taken only alongside a pop.
module ethernetsystem_cpu_oci_dct_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ethernetsystem_cpu_oci_dct_capture.sv
// Packs narrow trace entries into frames, buffers them in a FIFO and runs the end-of-test flush/drain.
module ethernetsystem_cpu_oci_dct_capture
    import ethernetsystem_cpu_oci_pkg::*;
#(
    parameter int ENTRY_W       = DEF_ENTRY_W,
    parameter int ENTRIES       = DEF_ENTRIES,
    parameter int COUNT_W       = DEF_COUNT_W,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int FLUSH_PARTIAL = 1
) (
    input  logic clk,
    input  logic reset,
    ethernetsystem_cpu_oci_dct_capture_if.master bus
);
    localparam int FRAME_W = ENTRY_W * ENTRIES;
    localparam int LEVEL_W = $clog2(DEPTH) + 1;
    localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(ENTRIES - 1);
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(ENTRIES);

    typedef struct packed {
        logic [FRAME_W-1:0] data;
        logic [COUNT_W-1:0] count;
    } rec_t;

    state_t             state;
    logic [FRAME_W-1:0] buffer;
    logic [COUNT_W-1:0] count;
    logic               ended;
    rec_t               push_rec;
    rec_t               head_rec;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LEVEL_W-1:0] level;
    logic               pop;
    logic               push_ok;
    logic               accept;
    logic               complete;
    logic               flush_push;
    logic               push;
    logic [FRAME_W-1:0] packed_buf;

    // A pop in the same cycle frees the slot, so a full FIFO never stalls a completing entry.
    assign pop        = !fifo_empty && bus.frame_ready;
    assign push_ok    = !fifo_full || pop;
    assign bus.in_ready = (state == ST_RUN) && (count != LAST_IDX || push_ok);
    assign accept     = bus.in_valid && bus.in_ready;
    assign complete   = accept && (count == LAST_IDX);
    assign flush_push = (state == ST_FLUSH) && (FLUSH_PARTIAL != 0) && (count != '0) && push_ok;
    assign push       = complete || flush_push;
    assign packed_buf = buffer | (FRAME_W'(bus.in_entry) << (int'(count) * ENTRY_W));

    always_comb begin
        push_rec.data  = buffer;
        push_rec.count = count;
        if (complete) begin
            push_rec.data  = packed_buf;
            push_rec.count = FULL_CNT;
        end
    end

    ethernetsystem_cpu_oci_dct_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (push_rec),
        .rdata (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_RUN;
            buffer <= '0;
            count  <= '0;
            ended  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (complete) begin
                        buffer <= '0;
                        count  <= '0;
                    end else if (accept) begin
                        buffer <= packed_buf;
                        count  <= count + COUNT_W'(1);
                    end
                    if (bus.test_ending) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    // Partial frame waits here until the FIFO can take it.
                    if (flush_push || count == '0 || FLUSH_PARTIAL == 0) begin
                        buffer <= '0;
                        count  <= '0;
                        state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (level == '0) begin
                        state <= ST_ENDED;
                        ended <= 1'b1;
                    end
                end
                ST_ENDED: ended <= 1'b1;
                default:  state <= ST_RUN;
            endcase
        end
    end

    assign bus.dct_buffer     = buffer;
    assign bus.dct_count      = count;
    assign bus.frame_valid    = !fifo_empty;
    assign bus.frame_data     = fifo_empty ? '0 : head_rec.data;
    assign bus.frame_count    = fifo_empty ? '0 : head_rec.count;
    assign bus.fifo_level     = level;
    assign bus.test_has_ended = ended;

endmodule

// File: tb/tb_ethernetsystem_cpu_oci_dct_capture.sv
// Randomised and directed bench for the trace capture stage against a queue-based reference model.
module tb_ethernetsystem_cpu_oci_dct_capture;
    import ethernetsystem_cpu_oci_pkg::*;

    localparam int ENTRY_W = 2;
    localparam int ENTRIES = 15;
    localparam int COUNT_W = 4;
    localparam int DEPTH   = 16;
    localparam int FRAME_W = 30;
    localparam int LEVEL_W = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ethernetsystem_cpu_oci_dct_capture_if #(
        .ENTRY_W(ENTRY_W), .FRAME_W(FRAME_W), .COUNT_W(COUNT_W), .LEVEL_W(LEVEL_W)
    ) ifa ();
    ethernetsystem_cpu_oci_dct_capture_if #(
        .ENTRY_W(ENTRY_W), .FRAME_W(FRAME_W), .COUNT_W(COUNT_W), .LEVEL_W(LEVEL_W)
    ) ifb ();

    ethernetsystem_cpu_oci_dct_capture #(
        .ENTRY_W(ENTRY_W), .ENTRIES(ENTRIES), .COUNT_W(COUNT_W), .DEPTH(DEPTH), .FLUSH_PARTIAL(1)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

    ethernetsystem_cpu_oci_dct_capture #(
        .ENTRY_W(ENTRY_W), .ENTRIES(ENTRIES), .COUNT_W(COUNT_W), .DEPTH(DEPTH), .FLUSH_PARTIAL(0)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    // Reference model for dut_a: phase 0 run, 1 flush, 2 drain, 3 ended.
    int                 m_phase;
    logic [FRAME_W-1:0] m_buf;
    int                 m_cnt;
    frame_t             exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic idle_inputs();
        ifa.in_valid = 1'b0; ifa.in_entry = '0; ifa.test_ending = 1'b0; ifa.frame_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_entry = '0; ifb.test_ending = 1'b0; ifb.frame_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_phase = 0; m_buf = '0; m_cnt = 0;
        exp_q.delete();
        check_val("rst_level", ifa.fifo_level, 0);
        check_val("rst_frame_valid", ifa.frame_valid, 0);
        check_val("rst_ended", ifa.test_has_ended, 0);
        check_val("rst_in_ready", ifa.in_ready, 1);
        check_val("rst_dct_count", ifa.dct_count, 0);
        check_val("rst_dct_buffer", ifa.dct_buffer, 0);
        check_val("rst_frame_data", ifa.frame_data, 0);
        check_val("rst_frame_count", ifa.frame_count, 0);
    endtask

    // One clock of dut_a: check combinational outputs, advance the model, check registered outputs.
    task automatic step(output bit acc);
        bit pp, room, rdy, te;
        int sz;
        logic [ENTRY_W-1:0] e;
        frame_t f;
        #1;
        sz   = exp_q.size();
        pp   = (sz != 0) && ifa.frame_ready;
        room = (sz < DEPTH) || pp;
        rdy  = (m_phase == 0) && ((m_cnt != ENTRIES - 1) || room);
        check_val("in_ready", ifa.in_ready, rdy);
        check_val("frame_valid", ifa.frame_valid, sz != 0);
        if (sz != 0) begin
            check_val("frame_data", ifa.frame_data, exp_q[0].data);
            check_val("frame_count", ifa.frame_count, exp_q[0].count);
        end
        acc = ifa.in_valid && rdy;
        e   = ifa.in_entry;
        te  = ifa.test_ending;
        @(posedge clk);
        if (pp) void'(exp_q.pop_front());
        case (m_phase)
            0: begin
                if (acc) begin
                    m_buf[m_cnt*ENTRY_W +: ENTRY_W] = e;
                    m_cnt++;
                    if (m_cnt == ENTRIES) begin
                        f.data = m_buf; f.count = COUNT_W'(ENTRIES);
                        exp_q.push_back(f);
                        m_buf = '0; m_cnt = 0;
                    end
                end
                if (te) m_phase = 1;
            end
            1: begin
                if (m_cnt != 0 && room) begin
                    f.data = m_buf; f.count = COUNT_W'(m_cnt);
                    exp_q.push_back(f);
                end
                if (m_cnt == 0 || room) begin
                    m_buf = '0; m_cnt = 0; m_phase = 2;
                end
            end
            2: if (sz == 0) m_phase = 3;
            default: ;
        endcase
        #1;
        check_val("dct_count", ifa.dct_count, m_cnt);
        check_val("dct_buffer", ifa.dct_buffer, m_buf);
        check_val("fifo_level", ifa.fifo_level, exp_q.size());
        check_val("test_has_ended", ifa.test_has_ended, m_phase == 3);
    endtask

    initial begin
        bit acc;
        bit seen_fv;
        int pat;
        idle_inputs();
        m_phase = 0; m_buf = '0; m_cnt = 0;
        @(posedge clk);
        do_reset();

        // FLUSH_PARTIAL=0 instance: partial frame is discarded.
        ifb.in_valid = 1'b1; ifb.in_entry = 2'b01;
        repeat (5) @(posedge clk);
        #1;
        ifb.in_valid = 1'b0;
        check_val("b_dct_count", ifb.dct_count, 5);
        check_val("b_dct_buffer", ifb.dct_buffer, 30'h155);
        ifb.test_ending = 1'b1;
        @(posedge clk);
        #1;
        ifb.test_ending = 1'b0;
        seen_fv = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (ifb.frame_valid) seen_fv = 1'b1;
        end
        check_val("b_ended", ifb.test_has_ended, 1);
        check_val("b_no_frame", seen_fv, 0);
        check_val("b_dct_count_clr", ifb.dct_count, 0);
        check_val("b_level", ifb.fifo_level, 0);
        check_val("b_in_ready", ifb.in_ready, 0);

        // One full frame of 2'b11.
        ifa.frame_ready = 1'b0; ifa.in_valid = 1'b1; ifa.in_entry = 2'b11;
        repeat (ENTRIES) step(acc);
        ifa.in_valid = 1'b0;
        check_val("full_frame_valid", ifa.frame_valid, 1);
        check_val("full_frame_data", ifa.frame_data, 30'h3FFFFFFF);
        check_val("full_frame_count", ifa.frame_count, 15);
        check_val("full_dct_count", ifa.dct_count, 0);
        ifa.frame_ready = 1'b1;
        step(acc);

        // Fill the FIFO with frame_ready low, then pop and push together.
        ifa.frame_ready = 1'b0; ifa.in_valid = 1'b1; pat = 0;
        repeat (280) begin
            ifa.in_entry = ENTRY_W'(pat);
            step(acc);
            if (acc) pat = (pat + 1) % 4;
        end
        check_val("fill_level", ifa.fifo_level, 16);
        check_val("fill_dct_count", ifa.dct_count, 14);
        check_val("fill_in_ready", ifa.in_ready, 0);
        ifa.frame_ready = 1'b1;
        ifa.in_entry = ENTRY_W'(pat);
        step(acc);
        check_val("swap_accepted", acc, 1);
        check_val("swap_level", ifa.fifo_level, 16);

        // Random traffic.
        repeat (400) begin
            ifa.in_valid    = ($urandom_range(0, 9) < 7);
            ifa.in_entry    = ENTRY_W'($urandom_range(0, 3));
            ifa.frame_ready = ($urandom_range(0, 1) == 1);
            step(acc);
        end

        // Partial frame flush and drain.
        do_reset();
        ifa.in_valid = 1'b1; ifa.in_entry = 2'b01;
        repeat (5) step(acc);
        ifa.in_valid = 1'b0; ifa.test_ending = 1'b1;
        step(acc);
        ifa.test_ending = 1'b0;
        repeat (2) step(acc);
        check_val("part_level", ifa.fifo_level, 1);
        check_val("part_frame_data", ifa.frame_data, 30'h155);
        check_val("part_frame_count", ifa.frame_count, 5);
        ifa.frame_ready = 1'b1;
        for (int i = 0; i < 10 && !ifa.test_has_ended; i++) step(acc);
        check_val("part_ended", ifa.test_has_ended, 1);
        ifa.in_valid = 1'b1; ifa.test_ending = 1'b1;
        repeat (3) step(acc);
        check_val("ended_sticky", ifa.test_has_ended, 1);

        // Reset in the middle of a drain.
        do_reset();
        ifa.in_valid = 1'b1;
        repeat (45) begin
            ifa.in_entry = ENTRY_W'($urandom_range(0, 3));
            step(acc);
        end
        ifa.in_valid = 1'b0; ifa.test_ending = 1'b1;
        step(acc);
        ifa.test_ending = 1'b0;
        repeat (2) step(acc);
        check_val("drain_level", ifa.fifo_level, 3);
        check_val("drain_not_ended", ifa.test_has_ended, 0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
